// File: rtl/exec_pkg.sv
// Execute-stage shared types: ALU/branch op codes, mul/div FSM states, op-class helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package exec_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_SRA   = 4'd7,
      OP_SLT   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_MUL   = 4'd10,
      OP_MULHU = 4'd11,
      OP_DIVU  = 4'd12,
      OP_REMU  = 4'd13
   } ex_op_e;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_EQ   = 3'd1,
      BR_NE   = 3'd2,
      BR_LT   = 3'd3,
      BR_GE   = 3'd4,
      BR_LTU  = 3'd5,
      BR_GEU  = 3'd6
   } br_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // True for the ops that go through the iterative multiply/divide unit.
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/ex_stage_md_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Latency: WIDTH cycles after start_i; done_o is high during the final step.
// Backpressure: none; a new start_i restarts the unit, the owner decides when to read result_o.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);
   import exec_pkg::*;

   localparam int CW = $clog2(WIDTH);

   // hi_q: product high half / partial remainder; lo_q: multiplier+product low / quotient
   logic             run_q;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] hi_q, lo_q, dv_q;

   logic             is_div;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic [WIDTH-1:0] hi_d, lo_d;

   assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

   // One iteration step: conditional add then shift right, or shift left then trial subtract.
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : {(WIDTH+1){1'b0}});
      div_sh   = {hi_q, lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, dv_q};
      if (is_div) begin
         if (!div_diff[WIDTH]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Latch operands on start, then step once per cycle while the counter runs WIDTH-1..0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         op_q  <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         dv_q  <= '0;
      end else if (start_i) begin
         run_q <= 1'b1;
         cnt_q <= CW'(WIDTH - 1);
         op_q  <= op_i;
         hi_q  <= '0;
         lo_q  <= a_i;
         dv_q  <= b_i;
      end else if (run_q) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         if (cnt_q == '0) begin
            run_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   // Divide by zero needs no special case: every trial subtract succeeds (quotient all-ones)
   // and the remainder register ends up holding the dividend.
   assign done_o   = run_q && (cnt_q == '0);
   assign result_o = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_q : lo_q;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU + branch resolve, optional iterative mul/div (EX_MULDIV_EN).
// Latency: ALU/branch 1 cycle after accept; mul/div WIDTH+1 cycles (1 cycle, result 0, without EX_MULDIV_EN).
// Backpressure: valid/ready; output held while out_ready_i is low, no accept until the output slot frees.
module ex_stage_md #(
   parameter  int WIDTH   = 32,
   parameter  int NUM_FWD = 3,
   localparam int SELW    = $clog2(NUM_FWD + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [3:0]               op_i,
   input  logic [2:0]               br_op_i,
   input  logic                     pred_taken_i,
   input  logic [SELW-1:0]          a_sel_i,
   input  logic [SELW-1:0]          b_sel_i,
   input  logic [WIDTH-1:0]         a_i,
   input  logic [WIDTH-1:0]         b_i,
   input  logic [NUM_FWD*WIDTH-1:0] fwd_i,
   input  logic                     flush_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [WIDTH-1:0]         result_o,
   output logic                     taken_o,
   output logic                     mispredict_o,
   output logic                     busy_o
);
   import exec_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   md_state_e        state_q;
   logic             out_valid_q, taken_q, mispred_q;
   logic             tk_pend_q, mp_pend_q;
   logic [WIDTH-1:0] result_q;

   logic [WIDTH-1:0] a_op, b_op, alu_res, md_res;
   logic [SHW-1:0]   shamt;
   logic             br_tk, br_mp, br_valid;
   logic             accept, md_go, md_done;

   // Operand select: 0 or any out-of-range select keeps the register-file value.
   always_comb begin
      a_op = a_i;
      b_op = b_i;
      for (int k = 0; k < NUM_FWD; k++) begin
         if (a_sel_i == SELW'(k + 1)) a_op = fwd_i[k*WIDTH +: WIDTH];
         if (b_sel_i == SELW'(k + 1)) b_op = fwd_i[k*WIDTH +: WIDTH];
      end
   end

   // Single-cycle ALU; M ops fall to the default and produce 0 here.
   always_comb begin
      shamt = b_op[SHW-1:0];
      case (op_i)
         OP_ADD:  alu_res = a_op + b_op;
         OP_SUB:  alu_res = a_op - b_op;
         OP_AND:  alu_res = a_op & b_op;
         OP_OR:   alu_res = a_op | b_op;
         OP_XOR:  alu_res = a_op ^ b_op;
         OP_SLL:  alu_res = a_op << shamt;
         OP_SRL:  alu_res = a_op >> shamt;
         OP_SRA:  alu_res = $signed(a_op) >>> shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_op < b_op)};
         default: alu_res = '0;
      endcase
   end

   // Branch compare; unknown codes behave like BR_NONE (never taken, never mispredicted).
   always_comb begin
      case (br_op_i)
         BR_EQ:   br_tk = (a_op == b_op);
         BR_NE:   br_tk = (a_op != b_op);
         BR_LT:   br_tk = ($signed(a_op) <  $signed(b_op));
         BR_GE:   br_tk = ($signed(a_op) >= $signed(b_op));
         BR_LTU:  br_tk = (a_op <  b_op);
         BR_GEU:  br_tk = (a_op >= b_op);
         default: br_tk = 1'b0;
      endcase
      br_valid = (br_op_i != BR_NONE) && (br_op_i <= BR_GEU);
      br_mp    = br_valid && (br_tk ^ pred_taken_i);
   end

   assign in_ready_o = (state_q == MD_IDLE) && (!out_valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready_o && !flush_i;

`ifdef EX_MULDIV_EN
   assign md_go  = accept && is_muldiv(op_i);
   assign busy_o = (state_q != MD_IDLE);

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .start_i  (md_go),
      .op_i     (op_i),
      .a_i      (a_op),
      .b_i      (b_op),
      .done_o   (md_done),
      .result_o (md_res)
   );
`else
   assign md_go   = 1'b0;
   assign md_done = 1'b0;
   assign md_res  = '0;
   assign busy_o  = 1'b0;
`endif

   // FSM plus output register: ALU ops load directly on accept, M ops load from DONE once the slot is free.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= MD_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         taken_q     <= 1'b0;
         mispred_q   <= 1'b0;
         tk_pend_q   <= 1'b0;
         mp_pend_q   <= 1'b0;
      end else if (flush_i) begin
         state_q     <= MD_IDLE;
         out_valid_q <= 1'b0;
      end else begin
         if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
         case (state_q)
            MD_IDLE: begin
               if (accept) begin
                  if (md_go) begin
                     state_q   <= MD_RUN;
                     tk_pend_q <= br_tk;
                     mp_pend_q <= br_mp;
                  end else begin
                     out_valid_q <= 1'b1;
                     result_q    <= alu_res;
                     taken_q     <= br_tk;
                     mispred_q   <= br_mp;
                  end
               end
            end
            MD_RUN: begin
               if (md_done) state_q <= MD_DONE;
            end
            MD_DONE: begin
               if (!out_valid_q || out_ready_i) begin
                  out_valid_q <= 1'b1;
                  result_q    <= md_res;
                  taken_q     <= tk_pend_q;
                  mispred_q   <= mp_pend_q;
                  state_q     <= MD_IDLE;
               end
            end
            default: state_q <= MD_IDLE;
         endcase
      end
   end

   assign out_valid_o  = out_valid_q;
   assign result_o     = result_q;
   assign taken_o      = taken_q;
   assign mispredict_o = mispred_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: reference model queue filled at accept, monitor pops at each output handshake.
// Latency: checks 1-cycle ALU and WIDTH+1-cycle mul/div (1 cycle, result 0, when EX_MULDIV_EN is not defined).
// Backpressure: exercises output hold, release-with-accept, random out_ready, flush and reset mid-operation.
module tb_ex_stage_md;
   import exec_pkg::*;

   localparam int W  = 32;
   localparam int NF = 3;
`ifdef EX_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif
   localparam int MD_LAT = MD_EN ? W + 1 : 1;

   typedef struct packed {
      logic [W-1:0] res;
      logic         tk;
      logic         mp;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid_i, in_ready_o, pred_taken_i, flush_i;
   logic [3:0]    op_i;
   logic [2:0]    br_op_i;
   logic [1:0]    a_sel_i, b_sel_i;
   logic [W-1:0]  a_i, b_i, result_o;
   logic [NF*W-1:0] fwd_i;
   logic          out_valid_o, out_ready_i, taken_o, mispredict_o, busy_o;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;
   bit   rnd_rdy = 1'b0;

   always #5 clk = ~clk;

   ex_stage_md dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .op_i         (op_i),
      .br_op_i      (br_op_i),
      .pred_taken_i (pred_taken_i),
      .a_sel_i      (a_sel_i),
      .b_sel_i      (b_sel_i),
      .a_i          (a_i),
      .b_i          (b_i),
      .fwd_i        (fwd_i),
      .flush_i      (flush_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .result_o     (result_o),
      .taken_o      (taken_o),
      .mispredict_o (mispredict_o),
      .busy_o       (busy_o)
   );

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Behavioural reference: plain arithmetic on the selected operands.
   function automatic exp_t model(input logic [3:0] op, input logic [2:0] br, input logic pred,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t              e;
      logic [2*W-1:0]    p;
      logic signed [W-1:0] sa, sbv;
      logic [4:0]        sh;
      logic              tk;
      p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      sa  = a;
      sbv = b;
      sh  = b[4:0];
      case (op)
         OP_ADD:   e.res = a + b;
         OP_SUB:   e.res = a - b;
         OP_AND:   e.res = a & b;
         OP_OR:    e.res = a | b;
         OP_XOR:   e.res = a ^ b;
         OP_SLL:   e.res = a << sh;
         OP_SRL:   e.res = a >> sh;
         OP_SRA:   e.res = sa >>> sh;
         OP_SLT:   e.res = {{(W-1){1'b0}}, (sa < sbv)};
         OP_SLTU:  e.res = {{(W-1){1'b0}}, (a < b)};
         OP_MUL:   e.res = MD_EN ? p[W-1:0] : {W{1'b0}};
         OP_MULHU: e.res = MD_EN ? p[2*W-1:W] : {W{1'b0}};
         OP_DIVU:  e.res = !MD_EN ? {W{1'b0}} : (b == 0) ? {W{1'b1}} : a / b;
         OP_REMU:  e.res = !MD_EN ? {W{1'b0}} : (b == 0) ? a : a % b;
         default:  e.res = {W{1'b0}};
      endcase
      case (br)
         BR_EQ:   tk = (a == b);
         BR_NE:   tk = (a != b);
         BR_LT:   tk = (sa < sbv);
         BR_GE:   tk = (sa >= sbv);
         BR_LTU:  tk = (a < b);
         BR_GEU:  tk = (a >= b);
         default: tk = 1'b0;
      endcase
      e.tk = tk;
      e.mp = (br >= BR_EQ && br <= BR_GEU) ? (tk ^ pred) : 1'b0;
      return e;
   endfunction

   function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] base,
                                         input logic [NF*W-1:0] fw);
      if (sel >= 2'd1 && int'(sel) <= NF) return fw[(int'(sel) - 1)*W +: W];
      return base;
   endfunction

   function automatic logic [W-1:0] rv();
      case ($urandom_range(0, 5))
         0: return {W{1'b0}};
         1: return {W{1'b1}};
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 40));
         default: return $urandom();
      endcase
   endfunction

   // Offer one op; the expected response is queued on the cycle it is accepted.
   task automatic issue(input logic [3:0] op, input logic [2:0] br, input logic pred,
                        input logic [1:0] asel, input logic [1:0] bsel,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [NF*W-1:0] fw,
                        input logic rdy, output int waited);
      exp_t e;
      @(posedge clk); #1;
      op_i = op; br_op_i = br; pred_taken_i = pred; a_sel_i = asel; b_sel_i = bsel;
      a_i = a; b_i = b; fwd_i = fw; out_ready_i = rdy; in_valid_i = 1'b1;
      e = model(op, br, pred, pick(asel, a, fw), pick(bsel, b, fw));
      waited = 0;
      while (1) begin
         @(negedge clk);
         if (in_ready_o) begin
            sb.push_back(e);
            break;
         end
         waited++;
         if (waited > 200) begin
            tests++; fails++;
            $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", op, waited);
            break;
         end
         @(posedge clk); #1;
         if (rnd_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      if (rnd_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
   endtask

   // Called right after an accept: measures cycles until out_valid_o rises.
   task automatic wait_out(input string nm, input int exp_lat, input logic exp_busy);
      int lat = 1;
      @(negedge clk);
      check({nm, "_busy"}, 32'(busy_o), 32'(exp_busy));
      while (!out_valid_o && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic run_vec(input string nm, input logic [3:0] op, input logic [2:0] br, input logic pred,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      int  w;
      bit  m;
      m = (op >= OP_MUL) && (op <= OP_REMU);
      issue(op, br, pred, 2'd0, 2'd0, a, b, {$urandom(), $urandom(), $urandom()}, 1'b1, w);
      wait_out(nm, m ? MD_LAT : 1, m && MD_EN);
   endtask

   task automatic drain();
      int n = 0;
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      while ((sb.size() != 0 || out_valid_o) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: one pop per output handshake.
   always @(negedge clk) begin
      if (mon_en && out_valid_o && out_ready_i) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_output: result %h with empty scoreboard", result_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_result", result_o, e.res);
            check("sb_taken", 32'(taken_o), 32'(e.tk));
            check("sb_mispredict", 32'(mispredict_o), 32'(e.mp));
         end
      end
   end

   initial begin
      int w;
      int seen;
      reset = 1'b0; in_valid_i = 1'b0; op_i = '0; br_op_i = '0; pred_taken_i = 1'b0;
      a_sel_i = '0; b_sel_i = '0; a_i = '0; b_i = '0; fwd_i = '0; flush_i = 1'b0; out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready_o), 32'd1);
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_taken", 32'(taken_o), 32'd0);
      check("rst_mispredict", 32'(mispredict_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      mon_en = 1'b1;

      // ADD with a taken from forwarding slot 0
      issue(OP_ADD, BR_NONE, 1'b0, 2'd1, 2'd0, 32'd99, 32'd7, {32'd3, 32'd9, 32'd5}, 1'b1, w);
      wait_out("add_fwd", 1, 1'b0);
      check("add_fwd_result", result_o, 32'd12);

      run_vec("mul",      OP_MUL,   BR_NONE, 1'b0, 32'd6, 32'd7);
      run_vec("mulhu",    OP_MULHU, BR_NONE, 1'b0, 32'hFFFF_FFFF, 32'd2);
      run_vec("divu",     OP_DIVU,  BR_NONE, 1'b0, 32'd100, 32'd7);
      run_vec("remu",     OP_REMU,  BR_NONE, 1'b0, 32'd100, 32'd7);
      run_vec("divu_z",   OP_DIVU,  BR_NONE, 1'b0, 32'd9, 32'd0);
      run_vec("remu_z",   OP_REMU,  BR_NONE, 1'b0, 32'd9, 32'd0);
      run_vec("br_lt",    OP_ADD,   BR_LT,   1'b0, 32'hFFFF_FFFF, 32'd1);
      check("br_lt_taken", 32'(taken_o), 32'd1);
      check("br_lt_mispredict", 32'(mispredict_o), 32'd1);
      run_vec("br_ltu",   OP_ADD,   BR_LTU,  1'b0, 32'hFFFF_FFFF, 32'd1);
      check("br_ltu_taken", 32'(taken_o), 32'd0);
      check("br_ltu_mispredict", 32'(mispredict_o), 32'd0);
      run_vec("sra",      OP_SRA,   BR_GE,   1'b1, 32'h8000_0010, 32'd36);
      drain();

      // Output held under backpressure, then release and accept in the same cycle
      issue(OP_ADD, BR_NONE, 1'b0, 2'd0, 2'd0, 32'd3, 32'd4, '0, 1'b0, w);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid_o), 32'd1);
         check("bp_result", result_o, 32'd7);
         check("bp_in_ready", 32'(in_ready_o), 32'd0);
      end
      issue(OP_XOR, BR_EQ, 1'b1, 2'd0, 2'd0, 32'h0000_F0F0, 32'h0000_0FF0, '0, 1'b1, w);
      check("bp_release_accept_wait", 32'(w), 32'd0);
      drain();

      // Randomised traffic with random forwarding and random downstream stalls
      rnd_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         issue(4'($urandom_range(0, 13)), 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rv(), rv(),
               {rv(), rv(), rv()}, 1'($urandom_range(0, 3) != 0), w);
      end
      rnd_rdy = 1'b0;
      drain();

      // Flush mid-operation: nothing may come out
      issue(OP_DIVU, BR_NONE, 1'b0, 2'd0, 2'd0, 32'd1000, 32'd7, '0, 1'b0, w);
      repeat (9) @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      void'(sb.pop_back());
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid_o), 32'd0);
      check("flush_in_ready", 32'(in_ready_o), 32'd1);
      check("flush_busy", 32'(busy_o), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid_o) seen = 1;
      end
      check("flush_no_output", 32'(seen), 32'd0);

      // Reset mid-operation: same outcome, output register cleared
      issue(OP_MUL, BR_EQ, 1'b1, 2'd0, 2'd0, 32'd11, 32'd11, '0, 1'b0, w);
      repeat (9) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      check("rstmid_out_valid", 32'(out_valid_o), 32'd0);
      check("rstmid_in_ready", 32'(in_ready_o), 32'd1);
      check("rstmid_busy", 32'(busy_o), 32'd0);
      check("rstmid_result", result_o, 32'd0);
      check("rstmid_taken", 32'(taken_o), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid_o) seen = 1;
      end
      check("rstmid_no_output", 32'(seen), 32'd0);

      // Recovery after the aborts
      run_vec("recover_sub", OP_SUB, BR_GEU, 1'b0, 32'd5, 32'd9);
      run_vec("recover_mul", OP_MUL, BR_NONE, 1'b0, 32'd1234, 32'd5678);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
